// File: rtl/calc_result_bcd_v_if.sv
// Handshake and display bundle between the result source and the BCD converter.
interface calc_result_bcd_v_if;
    logic        i_start;
    logic [7:0]  i_bin;
    logic        o_busy;
    logic        o_done;
    logic [11:0] o_bcd;
    logic        o_neg;
    logic [6:0]  o_seg_h;
    logic [6:0]  o_seg_t;
    logic [6:0]  o_seg_o;

    modport master (
        output i_start, i_bin,
        input  o_busy, o_done, o_bcd, o_neg, o_seg_h, o_seg_t, o_seg_o
    );

    modport slave (
        input  i_start, i_bin,
        output o_busy, o_done, o_bcd, o_neg, o_seg_h, o_seg_t, o_seg_o
    );
endinterface

// File: rtl/calc_result_bcd_v.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble, one bit per clock)
// with 7-segment decode. Define CALC_BCD_SIGNED_EN to treat i_bin as two's complement.
module calc_result_bcd_v #(
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    calc_result_bcd_v_if.slave  bus
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_reg;
    logic [19:0] shift_reg;
    logic [2:0]  cnt_reg;
    logic        done_reg;
    logic [11:0] bcd_reg;
    logic [11:0] adj_next;
    logic [19:0] shift_next;
    logic [7:0]  load_val;

    // Add-3 correction on each BCD nibble before the shift.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = shift_reg[8 + gi*4 +: 4];
            assign adj_next[gi*4 +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    endgenerate

    assign shift_next = {adj_next[10:0], shift_reg[7:0], 1'b0};

`ifdef CALC_BCD_SIGNED_EN
    logic sign_reg;
    logic neg_reg;
    assign load_val   = bus.i_bin[7] ? (8'd0 - bus.i_bin) : bus.i_bin;
    assign bus.o_neg  = neg_reg;
`else
    assign load_val   = bus.i_bin;
    assign bus.o_neg  = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            bcd_reg   <= '0;
`ifdef CALC_BCD_SIGNED_EN
            sign_reg  <= 1'b0;
            neg_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.i_start) begin
                        shift_reg <= {12'h000, load_val};
                        cnt_reg   <= '0;
`ifdef CALC_BCD_SIGNED_EN
                        sign_reg  <= bus.i_bin[7];
`endif
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_next;
                    cnt_reg   <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        bcd_reg   <= shift_next[19:8];
`ifdef CALC_BCD_SIGNED_EN
                        neg_reg   <= sign_reg;
`endif
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.o_busy = (state_reg == SHIFT);
    assign bus.o_done = done_reg;
    assign bus.o_bcd  = bcd_reg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Tens is only a leading zero when hundreds is also zero.
    logic [2:0]       blank;
    logic [2:0][6:0]  seg_out;

    assign blank[2] = BLANK_LZ && (bcd_reg[11:8] == 4'd0);
    assign blank[1] = blank[2] && (bcd_reg[7:4] == 4'd0);
    assign blank[0] = 1'b0;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_seg
            logic [6:0] lit;
            assign lit         = blank[gi] ? 7'h00 : seg7(bcd_reg[gi*4 +: 4]);
            assign seg_out[gi] = lit ^ {7{SEG_ACTIVE_LOW}};
        end
    endgenerate

    assign bus.o_seg_h = seg_out[2];
    assign bus.o_seg_t = seg_out[1];
    assign bus.o_seg_o = seg_out[0];

endmodule

// File: tb/tb_calc_result_bcd_v.sv
// Bench for calc_result_bcd_v: a default instance and an active-low, no-blanking instance
// run in lockstep against a decimal-arithmetic reference model.
module tb_calc_result_bcd_v;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    calc_result_bcd_v_if ifa ();
    calc_result_bcd_v_if ifb ();

    assign ifb.i_start = ifa.i_start;
    assign ifb.i_bin   = ifa.i_bin;

    calc_result_bcd_v dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa.slave));
    calc_result_bcd_v #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0))
        dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb.slave));

    localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        neg;
        bit          poke;
    } vec_t;

    vec_t        vecs [7];
    int          total = 0;
    int          bad   = 0;
    logic [11:0] cur_bcd;
    logic        cur_neg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the (possibly signed) value.
    function automatic logic [12:0] model(input logic [7:0] b);
        int   v;
        logic n;
`ifdef CALC_BCD_SIGNED_EN
        n = b[7];
        v = b[7] ? 256 - int'(b) : int'(b);
`else
        n = 1'b0;
        v = int'(b);
`endif
        return {n, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk_disp();
        logic [3:0] h, t, o;
        logic [6:0] eh, et, eo, bh, bt, bo;
        h  = cur_bcd[11:8];
        t  = cur_bcd[7:4];
        o  = cur_bcd[3:0];
        eh = (h == 0) ? 7'h00 : PAT[h];
        et = (h == 0 && t == 0) ? 7'h00 : PAT[t];
        eo = PAT[o];
        bh = ~PAT[h];
        bt = ~PAT[t];
        bo = ~PAT[o];
        chk("bcd",     ifa.o_bcd,   cur_bcd);
        chk("neg",     ifa.o_neg,   cur_neg);
        chk("seg_h",   ifa.o_seg_h, eh);
        chk("seg_t",   ifa.o_seg_t, et);
        chk("seg_o",   ifa.o_seg_o, eo);
        chk("bcd_b",   ifb.o_bcd,   cur_bcd);
        chk("seg_h_b", ifb.o_seg_h, bh);
        chk("seg_t_b", ifb.o_seg_t, bt);
        chk("seg_o_b", ifb.o_seg_o, bo);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_done", ifa.o_done, 0);
            chk("idle_busy", ifa.o_busy, 0);
            chk("idle_bcd",  ifa.o_bcd,  cur_bcd);
        end
    endtask

    // Issue one conversion; returns one step after the done edge so a following
    // call lands its start inside the o_done cycle.
    task automatic convert(input logic [7:0] bin, input logic [11:0] ebcd,
                           input logic eneg, input bit poke);
        @(negedge clk);
        ifa.i_start = 1'b1;
        ifa.i_bin   = bin;
        @(posedge clk); #1;
        ifa.i_start = 1'b0;
        ifa.i_bin   = ~bin;
        for (int c = 0; c < 8; c++) begin
            chk("busy",     ifa.o_busy, 1);
            chk("busy_b",   ifb.o_busy, 1);
            chk("no_done",  ifa.o_done, 0);
            chk("bcd_hold", ifa.o_bcd,  cur_bcd);
            if (poke && c == 3) begin
                ifa.i_start = 1'b1;
                ifa.i_bin   = 8'h00;
            end
            @(posedge clk); #1;
            ifa.i_start = 1'b0;
        end
        chk("done",   ifa.o_done, 1);
        chk("done_b", ifb.o_done, 1);
        chk("busy_end", ifa.o_busy, 0);
        cur_bcd = ebcd;
        cur_neg = eneg;
        chk_disp();
        $display("conv bin=%h bcd=%h neg=%b seg=%h/%h/%h", bin, ifa.o_bcd, ifa.o_neg,
                 ifa.o_seg_h, ifa.o_seg_t, ifa.o_seg_o);
    endtask

    initial begin
`ifdef CALC_BCD_SIGNED_EN
        vecs[0] = '{8'h19, 12'h025, 1'b0, 1'b0};
        vecs[1] = '{8'hC3, 12'h061, 1'b1, 1'b0};
        vecs[2] = '{8'h96, 12'h106, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 12'h001, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 12'h000, 1'b0, 1'b0};
        vecs[5] = '{8'hD3, 12'h045, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 12'h128, 1'b1, 1'b0};
`else
        vecs[0] = '{8'h19, 12'h025, 1'b0, 1'b0};
        vecs[1] = '{8'hC3, 12'h195, 1'b0, 1'b0};
        vecs[2] = '{8'h96, 12'h150, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 12'h255, 1'b0, 1'b1};
        vecs[4] = '{8'h00, 12'h000, 1'b0, 1'b0};
        vecs[5] = '{8'hD3, 12'h211, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 12'h128, 1'b0, 1'b0};
`endif
        rst         = 1'b1;
        ifa.i_start = 1'b0;
        ifa.i_bin   = 8'h00;
        cur_bcd     = 12'h000;
        cur_neg     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", ifa.o_busy, 0);
        chk("rst_done", ifa.o_done, 0);
        chk_disp();

        // Table entries run back-to-back except after the busy-poke case.
        for (int i = 0; i < 7; i++) begin
            convert(vecs[i].bin, vecs[i].bcd, vecs[i].neg, vecs[i].poke);
            if (vecs[i].poke) idle(10);
        end

        // Reset mid-conversion, with start asserted alongside reset.
        @(negedge clk);
        ifa.i_start = 1'b1;
        ifa.i_bin   = 8'hFF;
        @(posedge clk); #1;
        ifa.i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b1;
        ifa.i_start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b0;
        ifa.i_start = 1'b0;
        cur_bcd     = 12'h000;
        cur_neg     = 1'b0;
        chk("abort_busy", ifa.o_busy, 0);
        chk("abort_done", ifa.o_done, 0);
        chk_disp();
        idle(12);

        for (int i = 0; i < 30; i++) begin
            logic [7:0]  b;
            logic [12:0] m;
            b = 8'($urandom_range(0, 255));
            m = model(b);
            convert(b, m[11:0], m[12], $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) idle(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
